// File: rtl/opg_rx_checker_pkg.sv
// opg_rx_checker_pkg: scrambler geometry, default frame length and FSM encodings shared by the OPG checker
package opg_rx_checker_pkg;

    localparam int OPG_LFSR_W    = 7;
    localparam int OPG_TAP_A     = 6;
    localparam int OPG_TAP_B     = 3;
    localparam int OPG_FRAME_LEN = 127;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_SYNC  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

endpackage

// File: rtl/opg_rx_checker_lfsr.sv
// prbs7_lfsr: x^7+x^4+1 shift register that either loads serial data or free-runs on its own prediction
module prbs7_lfsr
    import opg_rx_checker_pkg::*;
#(
    parameter int W  = OPG_LFSR_W,
    parameter int TA = OPG_TAP_A,
    parameter int TB = OPG_TAP_B
)(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_load,
    input  logic i_di,
    output logic o_exp
);

    logic [W-1:0] r_sr;
    logic         w_in;

    assign o_exp = r_sr[TA] ^ r_sr[TB];
    assign w_in  = i_load ? i_di : o_exp;

    // shift lsb-in: received bit while synchronising, predicted bit while checking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sr <= '0;
        else if (i_en) r_sr <= {r_sr[W-2:0], w_in};
    end

endmodule

// File: rtl/opg_rx_checker.sv
// opg_rx_checker: requests an OPG frame, self-synchronises a PRBS7 predictor and counts bit errors
module opg_rx_checker
    import opg_rx_checker_pkg::*;
#(
    parameter int LFSR_W    = OPG_LFSR_W,
    parameter int TAP_A     = OPG_TAP_A,
    parameter int TAP_B     = OPG_TAP_B,
    parameter int FRAME_LEN = OPG_FRAME_LEN,
    parameter int TIMEOUT   = 1024,
    parameter int WIN_LEN   = 16,
    parameter int LOSS_TH   = 4,
    parameter int CNT_W     = 16
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_rd_en,
    input  logic             i_di,
    input  logic             i_di_vld,
    output logic             o_busy,
    output logic             o_locked,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic [7:0]       o_resync_cnt,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int SC_W = $clog2(LFSR_W + 1);
    localparam int WC_W = $clog2(WIN_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT);

    logic [2:0]       r_state;
    logic [SC_W-1:0]  r_sync_cnt;
    logic [WC_W-1:0]  r_win_cnt;
    logic [WC_W-1:0]  r_win_err;
    logic [TO_W-1:0]  r_idle_cnt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [7:0]       r_resync_cnt;
    logic             r_timeout;
    logic             r_pass;

    logic             w_exp;
    logic             w_run;
    logic             w_vld;
    logic             w_mis;
    logic [CNT_W-1:0] w_bit_nxt;
    logic [WC_W-1:0]  w_win_err_nxt;
    logic             w_frame_end;
    logic             w_sync_done;
    logic             w_loss;
    logic             w_win_wrap;
    logic             w_to;
    logic             w_pass_now;

    prbs7_lfsr #(
        .W  (LFSR_W),
        .TA (TAP_A),
        .TB (TAP_B)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_vld),
        .i_load  (r_state == S_SYNC),
        .i_di    (i_di),
        .o_exp   (w_exp)
    );

    // per-bit events; frame end outranks loss of lock, which is resolved in the FSM priority
    always_comb begin
        w_run         = (r_state == S_SYNC) || (r_state == S_CHECK);
        w_vld         = w_run && i_di_vld;
        w_mis         = (r_state == S_CHECK) && (i_di ^ w_exp);
        w_bit_nxt     = r_bit_cnt + 1'b1;
        w_win_err_nxt = r_win_err + WC_W'(w_mis);
        w_frame_end   = w_vld && (w_bit_nxt == CNT_W'(FRAME_LEN));
        w_sync_done   = (r_state == S_SYNC) && i_di_vld && (r_sync_cnt == SC_W'(LFSR_W - 1));
        w_loss        = (r_state == S_CHECK) && i_di_vld && (w_win_err_nxt == WC_W'(LOSS_TH));
        w_win_wrap    = (r_state == S_CHECK) && i_di_vld && (r_win_cnt == WC_W'(WIN_LEN - 1));
        w_to          = w_run && !i_di_vld && (r_idle_cnt == TO_W'(TIMEOUT - 2));
        w_pass_now    = (r_err_cnt == '0) && !r_timeout && (r_resync_cnt == '0);
    end

    // run control: request, sync, check with loss-of-lock recovery, timeout and result latching
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sync_cnt   <= '0;
            r_win_cnt    <= '0;
            r_win_err    <= '0;
            r_idle_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_err_cnt    <= '0;
            r_resync_cnt <= '0;
            r_timeout    <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_bit_cnt    <= '0;
                    r_err_cnt    <= '0;
                    r_resync_cnt <= '0;
                    r_timeout    <= 1'b0;
                    r_pass       <= 1'b0;
                    r_state      <= S_REQ;
                end
                S_REQ: begin
                    r_sync_cnt <= '0;
                    r_win_cnt  <= '0;
                    r_win_err  <= '0;
                    r_idle_cnt <= '0;
                    r_state    <= S_SYNC;
                end
                S_SYNC, S_CHECK: begin
                    r_idle_cnt <= i_di_vld ? '0 : r_idle_cnt + 1'b1;
                    if (i_di_vld) begin
                        r_bit_cnt <= w_bit_nxt;
                        if (w_mis && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
                        if (r_state == S_SYNC) begin
                            r_sync_cnt <= r_sync_cnt + 1'b1;
                            r_win_cnt  <= '0;
                            r_win_err  <= '0;
                        end else if (w_loss || w_win_wrap) begin
                            r_win_cnt  <= '0;
                            r_win_err  <= '0;
                        end else begin
                            r_win_cnt  <= r_win_cnt + 1'b1;
                            r_win_err  <= w_win_err_nxt;
                        end
                    end
                    if (w_frame_end) r_state <= S_FIN;
                    else if (w_to) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_FIN;
                    end else if (w_sync_done) r_state <= S_CHECK;
                    else if (w_loss) begin
                        r_sync_cnt <= '0;
                        if (!(&r_resync_cnt)) r_resync_cnt <= r_resync_cnt + 1'b1;
                        r_state    <= S_SYNC;
                    end
                end
                S_FIN: begin
                    r_pass  <= w_pass_now;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_rd_en      = (r_state == S_REQ);
    assign o_busy       = (r_state == S_REQ) || w_run;
    assign o_locked     = (r_state == S_CHECK);
    assign o_done       = (r_state == S_FIN);
    assign o_pass       = (r_state == S_FIN) ? w_pass_now : r_pass;
    assign o_timeout    = r_timeout;
    assign o_resync_cnt = r_resync_cnt;
    assign o_bit_cnt    = r_bit_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: doc/opg_rx_checker.md
Name: opg_rx_checker

Overview:
- Receive-side counterpart of the OFDM pattern generator (OPG).
- Issues the one-cycle read request (rd_en pulse) that starts OPG, then consumes OPG's serial bit stream (do/do_vld).
- Self-synchronises a local 802.11a-style LFSR (x^7+x^4+1) to the stream, counts bit errors over a frame, and reports pass/fail.
- Used as in-fabric BIST for OPG and as the bit-level sink in loopback builds.

Parameters:
- LFSR_W, 7, scrambler/PRBS register width.
- TAP_A, 6, first feedback tap index (x^7).
- TAP_B, 3, second feedback tap index (x^4).
- FRAME_LEN, 127, valid bits per frame, sync bits included.
- TIMEOUT, 1024, max clk cycles without di_vld in SYNC/CHECK before abort.
- WIN_LEN, 16, loss-of-lock observation window in checked bits.
- LOSS_TH, 4, errors within one window that force resync.
- CNT_W, 16, width of bit/error counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a check run when idle, ignored otherwise.
- rd_en  out  1  one-cycle request pulse to OPG.
- di  in  1  serial data from OPG do.
- di_vld  in  1  qualifies di, from OPG do_vld.
- busy  out  1  high from start acceptance until done.
- locked  out  1  high while in CHECK.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  valid from done; 1 when err_cnt==0, no timeout and no resync.
- timeout  out  1  sticky until next start; run aborted by TIMEOUT.
- resync_cnt  out  8  number of loss-of-lock resyncs this run, saturating at 255.
- bit_cnt  out  CNT_W  valid bits consumed this run.
- err_cnt  out  CNT_W  mismatches in CHECK, saturating at all-ones.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, LFSR 0, counters 0.
- FSM states: IDLE, REQ, SYNC, CHECK, FIN.
- IDLE:
  - On start: clear bit_cnt, err_cnt, resync_cnt, timeout and pass.
  - Go to REQ; busy rises the next cycle.
- REQ:
  - rd_en=1 for exactly this one cycle.
  - Next state is SYNC.
- SYNC:
  - Each di_vld shifts di into LFSR (lsb in, msb out) and increments bit_cnt; no comparison.
  - After LFSR_W valid bits since entry, go to CHECK.
- CHECK:
  - Expected bit = lfsr[TAP_A]^lfsr[TAP_B].
  - Each di_vld: compare di to expected; LFSR shifts in the expected bit, never di, so errors do not propagate.
  - bit_cnt increments; err_cnt increments on mismatch.
- Loss of lock:
  - A window counter counts checked bits; a separate counter counts mismatches within the window; both clear at WIN_LEN.
  - If window errors reach LOSS_TH, go to SYNC with a fresh sync count, increment resync_cnt and clear the window.
  - bit_cnt keeps counting across the resync.
- End of frame: when bit_cnt reaches FRAME_LEN in SYNC or CHECK, go to FIN on the bit that reaches it.
  - That bit is still compared if in CHECK.
- Timeout:
  - An idle counter runs in SYNC/CHECK, clearing on each di_vld.
  - At TIMEOUT: set timeout and go to FIN.
- FIN:
  - done=1 for one cycle.
  - pass = (err_cnt==0 && !timeout && resync_cnt==0).
  - busy falls the same cycle; return to IDLE.
  - Counters and pass hold until the next start.
- Illegal or ignored inputs:
  - start while busy is ignored.
  - di_vld in IDLE, REQ or FIN is ignored; no count, no error.
- Simultaneous events: the frame-end condition wins over loss-of-lock on the same bit.
- Reset mid-run: immediate return to IDLE with all outputs 0; no done is issued.
- An all-zero LFSR after SYNC is legal; it predicts all zeros.

Decomposition:
- Shared package/header `global_define.vh`:
  - OFDM scrambler width and taps (LFSR_W, TAP_A, TAP_B).
  - Default OPG frame length.
  - FSM state encodings, localparams of width 3.
- Natural sub-module: `prbs7_lfsr`, holding the shift register with load-serial and free-run modes plus an expected-bit output.
  - The same block can be reused by a future OPG rewrite.

Test Plan:
1. Reset, start pulse, model OPG with seed 7'b1111111 emitting 127 bits (first 8: 0,0,0,0,1,1,1,0) one per cycle -> rd_en single pulse 1 cycle after start; locked after bit 7; done with pass=1, bit_cnt=127, err_cnt=0.
2. Same stream, di inverted on bits 20 and 60 -> err_cnt=2, resync_cnt=0, pass=0, bit_cnt=127.
3. Bits 30..33 inverted (4 errors in one window) -> resync_cnt=1, locked drops for 7 valid bits, then re-locks; pass=0.
4. Stream stops after 50 bits -> done exactly TIMEOUT cycles after the last di_vld; timeout=1, bit_cnt=50, pass=0.
5. di_vld gapped (1 valid per 3 cycles) and start re-pulsed mid-run -> second start ignored, result identical to scenario 1.
6. rst_n asserted during CHECK at bit 80 -> all outputs 0 at once, no done; a fresh start then completes with pass=1.
